// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, datapath op codes,
// blink masks and small helpers used by the controller and its debouncers.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_ADJ_MIN = 3'd3,
        ST_ADJ_SEC = 3'd4
    } state_t;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_ADJ_MIN = 2'd2;
    localparam logic [1:0] OP_ADJ_SEC = 2'd3;

    localparam logic [3:0] MASK_MIN = 4'b1100;
    localparam logic [3:0] MASK_SEC = 4'b0011;

    // Counter width able to hold 0..div-1 (at least one bit).
    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Running/adjust destination picked from the debounced switches.
    function automatic state_t target_state(input logic adj, input logic sel);
        if (!adj)
            return ST_RUN;
        else if (!sel)
            return ST_ADJ_MIN;
        else
            return ST_ADJ_SEC;
    endfunction

    function automatic logic is_adj(input state_t s);
        return (s == ST_ADJ_MIN) || (s == ST_ADJ_SEC);
    endfunction

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-sample counter and optional rise pulse.
// PULSE=0 outputs the debounced level, PULSE=1 a one-cycle pulse on its 0->1 edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CNT = 1000000,
    parameter bit PULSE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_q
);

    localparam int            CW      = cnt_w(DEB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_q;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so it measures consecutive samples of the new value.
    assign w_accept = (r_sync1 != r_level) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_q     <= 1'b0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            if ((r_sync1 == r_level) || w_accept)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_accept)
                r_level <= r_sync1;
            if (PULSE)
                r_q <= w_accept & r_sync1;
            else
                r_q <= w_accept ? r_sync1 : r_level;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: input conditioning, mode FSM, count/clear strobes,
// blink mask and scan select. Optional lap hold guarded by STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int ONE_HZ_DIV = 100000000,
    parameter int ADJ_DIV    = 50000000,
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CNT    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       clr_btn,
    input  logic       adj_sw,
    input  logic       sel_sw,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap_btn,
    output logic       disp_hold,
`endif
    output logic       cnt_stb,
    output logic [1:0] cnt_op,
    output logic       clr,
    output logic [3:0] blink_mask,
    output logic [1:0] scan_sel,
    output logic [2:0] state_o
);

    localparam int            W1   = cnt_w(ONE_HZ_DIV);
    localparam int            WA   = cnt_w(ADJ_DIV);
    localparam int            WS   = cnt_w(SCAN_DIV);
    localparam logic [W1-1:0] MAX1 = W1'(ONE_HZ_DIV - 1);
    localparam logic [WA-1:0] MAXA = WA'(ADJ_DIV - 1);
    localparam logic [WS-1:0] MAXS = WS'(SCAN_DIV - 1);

    logic          w_pause_prs;
    logic          w_clr_prs;
    logic          w_adj;
    logic          w_sel;

    logic [W1-1:0] r_div_1hz;
    logic [WA-1:0] r_div_adj;
    logic [WS-1:0] r_div_scan;
    logic          w_tick_1hz;
    logic          w_tick_adj;
    logic          w_tick_scan;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_pause;
    logic          w_pause_nxt;
    logic          r_phase;
    logic          r_clr;
    logic          r_stb;
    logic [1:0]    r_op;
    logic [3:0]    r_mask;
    logic [1:0]    r_scan;
    logic          w_stb;
    logic [1:0]    w_op;
    logic [3:0]    w_mask;

    btn_debounce #(.DEB_CNT(DEB_CNT), .PULSE(1'b1)) u_deb_pause (
        .clk(clk), .rst(rst), .i_raw(pause_btn), .o_q(w_pause_prs)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT), .PULSE(1'b1)) u_deb_clr (
        .clk(clk), .rst(rst), .i_raw(clr_btn), .o_q(w_clr_prs)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT), .PULSE(1'b0)) u_deb_adj (
        .clk(clk), .rst(rst), .i_raw(adj_sw), .o_q(w_adj)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT), .PULSE(1'b0)) u_deb_sel (
        .clk(clk), .rst(rst), .i_raw(sel_sw), .o_q(w_sel)
    );

    assign w_tick_1hz  = (r_div_1hz  == MAX1);
    assign w_tick_adj  = (r_div_adj  == MAXA);
    assign w_tick_scan = (r_div_scan == MAXS);

    // Free-running clock-enable prescalers, realigned by a clear press.
    always_ff @(posedge clk) begin
        if (!rst || w_clr_prs) begin
            r_div_1hz  <= '0;
            r_div_adj  <= '0;
            r_div_scan <= '0;
        end else begin
            r_div_1hz  <= w_tick_1hz  ? '0 : r_div_1hz  + 1'b1;
            r_div_adj  <= w_tick_adj  ? '0 : r_div_adj  + 1'b1;
            r_div_scan <= w_tick_scan ? '0 : r_div_scan + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_scan <= 2'd0;
        else if (w_tick_scan)
            r_scan <= r_scan + 2'd1;
    end

    // Every state has the same exits, so next state is one priority chain;
    // CLEAR stays a single cycle because the clear press is itself one cycle.
    always_comb begin
        w_pause_nxt = r_pause;
        if (w_clr_prs)
            w_pause_nxt = 1'b0;
        else if (w_pause_prs)
            w_pause_nxt = ~r_pause;

        w_state_nxt = target_state(w_adj, w_sel);
        if (w_clr_prs)
            w_state_nxt = ST_CLEAR;
        else if (w_pause_nxt)
            w_state_nxt = ST_PAUSED;
    end

    // Strobes follow the state as registered on the tick cycle.
    always_comb begin
        w_stb  = 1'b0;
        w_op   = OP_NONE;
        w_mask = 4'b0000;
        case (r_state)
            ST_RUN: begin
                if (w_tick_1hz) begin
                    w_stb = 1'b1;
                    w_op  = OP_RUN;
                end
            end
            ST_ADJ_MIN: begin
                if (w_tick_adj) begin
                    w_stb = 1'b1;
                    w_op  = OP_ADJ_MIN;
                end
                if (r_phase)
                    w_mask = MASK_MIN;
            end
            ST_ADJ_SEC: begin
                if (w_tick_adj) begin
                    w_stb = 1'b1;
                    w_op  = OP_ADJ_SEC;
                end
                if (r_phase)
                    w_mask = MASK_SEC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_pause <= 1'b0;
            r_phase <= 1'b0;
            r_clr   <= 1'b0;
            r_stb   <= 1'b0;
            r_op    <= OP_NONE;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_pause <= w_pause_nxt;
            // Blink phase restarts on entering any adjust state, including
            // a direct minutes<->seconds switch.
            if (is_adj(w_state_nxt) && (w_state_nxt == r_state)) begin
                if (w_tick_adj)
                    r_phase <= ~r_phase;
            end else begin
                r_phase <= 1'b0;
            end
            r_clr  <= (r_state == ST_CLEAR);
            r_stb  <= w_stb;
            r_op   <= w_op;
            r_mask <= w_mask;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic w_lap_prs;
    logic r_hold;

    btn_debounce #(.DEB_CNT(DEB_CNT), .PULSE(1'b1)) u_deb_lap (
        .clk(clk), .rst(rst), .i_raw(lap_btn), .o_q(w_lap_prs)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_hold <= 1'b0;
        else if ((w_state_nxt != ST_RUN) || w_clr_prs)
            r_hold <= 1'b0;
        else if ((r_state == ST_RUN) && w_lap_prs)
            r_hold <= ~r_hold;
    end

    assign disp_hold = r_hold;
`endif

    assign cnt_stb    = r_stb;
    assign cnt_op     = r_op;
    assign clr        = r_clr;
    assign blink_mask = r_mask;
    assign scan_sel   = r_scan;
    assign state_o    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: table vectors, hand sequences and
// random stimulus against a cycle reference model. Lap checks need STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    localparam int ONE = 10;
    localparam int ADJ = 4;
    localparam int SCN = 2;
    localparam int DEB = 3;

    localparam int S_CLEAR = 0, S_RUN = 1, S_PAUSED = 2, S_ADJMIN = 3, S_ADJSEC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause_btn = 1'b0, clr_btn = 1'b0, adj_sw = 1'b0, sel_sw = 1'b0, lap_btn = 1'b0;
    logic       cnt_stb, clr, disp_hold;
    logic [1:0] cnt_op, scan_sel;
    logic [3:0] blink_mask;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .ONE_HZ_DIV(ONE), .ADJ_DIV(ADJ), .SCAN_DIV(SCN), .DEB_CNT(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pause_btn(pause_btn),
        .clr_btn(clr_btn),
        .adj_sw(adj_sw),
        .sel_sw(sel_sw),
`ifdef STOPWATCH_LAP_EN
        .lap_btn(lap_btn),
        .disp_hold(disp_hold),
`endif
        .cnt_stb(cnt_stb),
        .cnt_op(cnt_op),
        .clr(clr),
        .blink_mask(blink_mask),
        .scan_sel(scan_sel),
        .state_o(state_o)
    );

`ifndef STOPWATCH_LAP_EN
    assign disp_hold = 1'b0;
`endif

    // Reference model: inputs 0=pause 1=clr 2=adj 3=sel 4=lap
    int          m_state;
    bit          m_pause, m_phase, m_hold;
    int unsigned m_n;
    bit          s0[5], s1[5], lvl[5], prs[5];
    bit          hist[5][DEB];
    bit          e_clr, e_stb;
    int          e_op;
    logic [3:0]  e_mask;
    logic [1:0]  e_scan;

    task automatic model_step();
        bit raw[5];
        bit t1, ta, ts, pn, all_eq, samp;
        int tgt, sn;
        raw = '{pause_btn, clr_btn, adj_sw, sel_sw, lap_btn};
        if (!rst) begin
            m_state = S_CLEAR; m_pause = 0; m_phase = 0; m_hold = 0; m_n = 0;
            e_clr = 0; e_stb = 0; e_op = 0; e_mask = 4'd0; e_scan = 2'd0;
            for (int i = 0; i < 5; i++) begin
                s0[i] = 0; s1[i] = 0; lvl[i] = 0; prs[i] = 0;
                for (int k = 0; k < DEB; k++) hist[i][k] = 0;
            end
            return;
        end
        // Elapsed cycles since the last realignment drive all three ticks.
        t1 = (m_n % ONE) == ONE - 1;
        ta = (m_n % ADJ) == ADJ - 1;
        ts = (m_n % SCN) == SCN - 1;
        tgt = !lvl[2] ? S_RUN : (!lvl[3] ? S_ADJMIN : S_ADJSEC);
        pn = prs[1] ? 1'b0 : (prs[0] ? !m_pause : m_pause);
        sn = prs[1] ? S_CLEAR : (pn ? S_PAUSED : tgt);

        e_clr  = (m_state == S_CLEAR);
        e_stb  = (m_state == S_RUN && t1) || ((m_state == S_ADJMIN || m_state == S_ADJSEC) && ta);
        e_op   = !e_stb ? 0 : (m_state == S_RUN ? 1 : (m_state == S_ADJMIN ? 2 : 3));
        e_mask = (m_phase && m_state == S_ADJMIN) ? 4'b1100 :
                 (m_phase && m_state == S_ADJSEC) ? 4'b0011 : 4'b0000;
        if (ts) e_scan = e_scan + 2'd1;

        if ((sn == S_ADJMIN || sn == S_ADJSEC) && sn == m_state)
            m_phase = ta ? !m_phase : m_phase;
        else
            m_phase = 0;
        if (sn != S_RUN || prs[1])
            m_hold = 0;
        else if (m_state == S_RUN && prs[4])
            m_hold = !m_hold;
        m_n     = prs[1] ? 0 : m_n + 1;
        m_pause = pn;
        m_state = sn;

        // A new level is accepted once the last DEB synchronized samples agree.
        for (int i = 0; i < 5; i++) begin
            samp = s1[i];
            for (int k = DEB - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = samp;
            all_eq = 1;
            for (int k = 0; k < DEB; k++) if (hist[i][k] != samp) all_eq = 0;
            prs[i] = 0;
            if (all_eq && samp != lvl[i]) begin
                prs[i] = samp;
                lvl[i] = samp;
            end
            s1[i] = s0[i];
            s0[i] = raw[i];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_state));
        chk("clr", 32'(clr), 32'(e_clr));
        chk("cnt_stb", 32'(cnt_stb), 32'(e_stb));
        chk("cnt_op", 32'(cnt_op), 32'(e_op));
        chk("blink_mask", 32'(blink_mask), 32'(e_mask));
        chk("scan_sel", 32'(scan_sel), 32'(e_scan));
`ifdef STOPWATCH_LAP_EN
        chk("disp_hold", 32'(disp_hold), 32'(m_hold));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        bit   pause, clrb, adj, sel;
        int   cycles;
        int   exp_state;
        bit   exp_clr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int stb_seen;
        int guard;

        vecs[0]  = '{0, 0, 0, 0, 20, S_RUN,    0};
        vecs[1]  = '{1, 0, 0, 0,  5, S_RUN,    0};
        vecs[2]  = '{0, 0, 0, 0, 50, S_PAUSED, 0};
        vecs[3]  = '{1, 0, 0, 0,  5, S_PAUSED, 0};
        vecs[4]  = '{0, 0, 0, 0, 20, S_RUN,    0};
        vecs[5]  = '{1, 0, 0, 0,  1, S_RUN,    0};
        vecs[6]  = '{0, 0, 0, 0, 20, S_RUN,    0};
        vecs[7]  = '{0, 0, 1, 0, 30, S_ADJMIN, 0};
        vecs[8]  = '{0, 0, 1, 1, 30, S_ADJSEC, 0};
        vecs[9]  = '{0, 0, 0, 1, 20, S_RUN,    0};
        vecs[10] = '{1, 1, 0, 0,  5, S_RUN,    0};
        vecs[11] = '{0, 0, 0, 0,  1, S_CLEAR,  0};
        vecs[12] = '{0, 0, 0, 0,  1, S_RUN,    1};
        vecs[13] = '{0, 0, 0, 0, 20, S_RUN,    0};

        // Reset state
        rst = 1'b0;
        repeat (3) cyc();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_outs", {26'd0, cnt_stb, cnt_op, clr, scan_sel}, 0);
        rst = 1'b1;
        cyc();
        chk("rel_clr", 32'(clr), 1);
        chk("rel_state", 32'(state_o), S_RUN);
        cyc();
        chk("rel_clr_once", 32'(clr), 0);

        for (int v = 0; v < 14; v++) begin
            pause_btn = vecs[v].pause;
            clr_btn   = vecs[v].clrb;
            adj_sw    = vecs[v].adj;
            sel_sw    = vecs[v].sel;
            repeat (vecs[v].cycles) cyc();
            chk($sformatf("vec%0d_state", v), 32'(state_o), 32'(vecs[v].exp_state));
            chk($sformatf("vec%0d_clr", v), 32'(clr), 32'(vecs[v].exp_clr));
        end

        // Run tick coincident with the state change into ADJ_MIN
        pause_btn = 0; clr_btn = 0; adj_sw = 0; sel_sw = 0;
        guard = 0;
        while ((m_n % ONE) != 4 && guard < 2 * ONE) begin
            cyc();
            guard++;
        end
        chk("coinc_align", 32'(guard < 2 * ONE), 1);
        adj_sw = 1;
        repeat (6) cyc();
        chk("coinc_stb", 32'(cnt_stb), 1);
        chk("coinc_op", 32'(cnt_op), 1);
        chk("coinc_state", 32'(state_o), S_ADJMIN);
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!e_stb && guard < 2 * ADJ);
        chk("coinc_next_stb", 32'(cnt_stb), 1);
        chk("coinc_next_op", 32'(cnt_op), 2);

        // Reset in the middle of adjust
        repeat (5) cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_outs", {22'd0, cnt_stb, cnt_op, clr, blink_mask, scan_sel}, 0);
        rst = 1'b1;
        adj_sw = 0;
        repeat (15) cyc();
        chk("midrst_run", 32'(state_o), S_RUN);

`ifdef STOPWATCH_LAP_EN
        lap_btn = 1;
        repeat (5) cyc();
        lap_btn = 0;
        repeat (3) cyc();
        chk("lap_hold", 32'(disp_hold), 1);
        stb_seen = 0;
        repeat (12) begin
            cyc();
            if (cnt_stb) stb_seen++;
        end
        chk("lap_counting", 32'(stb_seen > 0), 1);
        chk("lap_hold_kept", 32'(disp_hold), 1);
        pause_btn = 1;
        repeat (5) cyc();
        pause_btn = 0;
        repeat (2) cyc();
        chk("lap_pause_state", 32'(state_o), S_PAUSED);
        chk("lap_pause_hold", 32'(disp_hold), 0);
        pause_btn = 1;
        repeat (5) cyc();
        pause_btn = 0;
        repeat (5) cyc();
`endif

        // Random stimulus against the model
        for (int s = 0; s < 60; s++) begin
            adj_sw    = ($urandom_range(0, 2) != 0);
            sel_sw    = $urandom_range(0, 1);
            pause_btn = ($urandom_range(0, 3) == 0);
            clr_btn   = ($urandom_range(0, 7) == 0);
            lap_btn   = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Single-clock mode controller and scheduler for the MM:SS stopwatch digit datapath and the 4-digit 7-segment scan.
- Debounces the pause/clear buttons and the adjust/select switches, and runs the mode FSM.
- Issues one-cycle count strobes with an op code, a clear strobe, a per-digit blink mask and the scan digit select.
- Replaces derived clocks with clock enables; sits between the board I/O and the digit counters/segment decoder.

Parameters:
- ONE_HZ_DIV, 100000000: clk cycles per run-mode count tick.
- ADJ_DIV, 50000000: clk cycles per adjust-mode count tick and blink toggle.
- SCAN_DIV, 100000: clk cycles per scan digit advance.
- DEB_CNT, 1000000: consecutive stable cycles needed to accept a new input level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- pause_btn  in  1  raw pause button, asynchronous
- clr_btn  in  1  raw clear button, asynchronous
- adj_sw  in  1  raw adjust switch (1 = adjust)
- sel_sw  in  1  raw select switch (0 = minutes, 1 = seconds)
- cnt_stb  out  1  one-cycle count strobe to the datapath
- cnt_op  out  2  0 NONE, 1 RUN (sec +1 with carry into min), 2 ADJ_MIN (min +1, wrap 59->0), 3 ADJ_SEC (sec +1, wrap 59->0, no carry)
- clr  out  1  one-cycle strobe: zero all digits
- blink_mask  out  4  1 = blank digit; bit3..0 = min tens, min ones, sec tens, sec ones
- scan_sel  out  2  active digit index for the segment mux
- state_o  out  3  current FSM state

Behaviour:
- Reset (rst=0 at a clk edge): state=CLEAR, all outputs 0, all prescalers 0, pause flag 0, blink phase 0, debounced levels 0.
- Input conditioning: each raw input goes through a 2-FF synchronizer, then a debouncer. The debounced level updates only after DEB_CNT consecutive equal samples.
- Press events: pause_press and clr_press are one-cycle pulses on the debounced 0->1 edge.
- Pause flag: toggles on pause_press; cleared by clr_press.
- Prescalers: free-running, each emits a one-cycle tick at count DIV-1 and wraps to 0. All are zeroed on clr_press.
- FSM states: CLEAR=0, RUN=1, PAUSED=2, ADJ_MIN=3, ADJ_SEC=4.
  - CLEAR lasts exactly one cycle and drives clr=1. It then leaves by priority: pause flag -> PAUSED; adj=0 -> RUN; sel=0 -> ADJ_MIN; else ADJ_SEC.
  - Any state: clr_press -> CLEAR. This has highest priority, including over a simultaneous pause_press.
  - RUN, ADJ_MIN, ADJ_SEC: pause flag 1 -> PAUSED. Otherwise the target is chosen from adj/sel as above, with no intermediate state.
  - PAUSED: pause flag 0 -> target chosen from adj/sel.
- Count strobes:
  - In RUN, cnt_stb=1 and cnt_op=1 on the cycle after a 1 Hz tick.
  - In ADJ_MIN or ADJ_SEC, cnt_stb=1 on the cycle after an adjust tick, with cnt_op=2 or 3.
  - The strobe uses the state registered on the tick cycle, so a tick coincident with a state change follows the old state.
  - cnt_stb is never 1 in CLEAR or PAUSED. cnt_op=0 whenever cnt_stb=0.
- Blink:
  - The phase toggles on each adjust tick while in an ADJ state; it is forced to 0 in any other state.
  - blink_mask=4'b1100 in ADJ_MIN with phase 1; 4'b0011 in ADJ_SEC with phase 1; otherwise 0.
  - Entering an ADJ state starts with phase 0.
- Scan: scan_sel increments on each scan tick, wraps 3->0, and is independent of state.
- Latency: debounced input -> state change is 1 cycle; state -> outputs is registered, +1 cycle.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined:
  - Adds input lap_btn (raw, debounced like the other inputs) and output disp_hold (1 bit).
  - In RUN, each lap press toggles disp_hold; counting continues.
  - Leaving RUN, or any clr, forces disp_hold=0.
- When undefined: neither port exists, and the datapath ties its hold input to 0.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding enum (CLEAR/RUN/PAUSED/ADJ_MIN/ADJ_SEC);
  - the cnt_op encoding constants;
  - the blink mask constants MASK_MIN=4'b1100 and MASK_SEC=4'b0011.
- One sub-module, btn_debounce (synchronizer + stable counter + rise pulse), parameterized by DEB_CNT and instantiated once per input.

Test Plan (ONE_HZ_DIV=10, ADJ_DIV=4, SCAN_DIV=2, DEB_CNT=3):
- Reset release with adj=0, pause=0 -> clr=1 for exactly 1 cycle, then state RUN; cnt_stb/op=1 every 10 cycles; scan_sel steps 0,1,2,3,0 every 2 cycles.
- Pause pulse held 5 cycles -> state PAUSED, no cnt_stb for 50 cycles. A second press -> RUN resumes. A 1-cycle glitch (< DEB_CNT) -> no toggle.
- adj_sw=1, sel_sw=0 -> ADJ_MIN; cnt_op=2 strobes every 4 cycles; blink_mask alternates 0000/1100 every 4 cycles. Switching sel=1 -> ADJ_SEC, op=3, mask 0011.
- clr_btn and pause_btn pressed on the same cycle while RUN -> CLEAR (clr=1), pause flag 0, then RUN.
- Tick coincident with adj 0->1 -> that strobe carries op=1; the next strobe op=2 after 4 cycles. rst=0 mid-ADJ -> all outputs 0 on the next edge.
- With STOPWATCH_LAP_EN: lap press in RUN -> disp_hold=1 while cnt_stb continues; pause -> disp_hold=0.
